axis_sample_batcher: RTL



---
 rtl/batcher_pkg.sv | 22 ++
 rtl/batcher_fifo.sv | 73 +++++++
 rtl/axis_sample_batcher.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/batcher_pkg.sv
// Shared definitions for the sample batcher.
//   batcher_state_t : output framer states
//   DEFAULT_MAGIC   : first header word of every frame
//   SEQ_W / LEN_W   : header field widths (sequence number, batch length)
//   DROP_W          : width of the saturating drop counter
package batcher_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        HDR_MAGIC = 3'd1,
        HDR_INFO  = 3'd2,
        DATA_HI   = 3'd3,
        DATA_LO   = 3'd4,
        CHECKSUM  = 3'd5
    } batcher_state_t;

    localparam logic [31:0] DEFAULT_MAGIC = 32'h5344524D;
    localparam int SEQ_W  = 16;
    localparam int LEN_W  = 8;
    localparam int DROP_W = 16;

endpackage

// File: rtl/batcher_fifo.sv
// Single-clock first-word-fall-through record FIFO.
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   push, wdata     : write request (ignored while full)
//   pop             : read request (ignored while empty)
//   head            : oldest entry, valid whenever !empty
//   next_head       : entry behind head, valid when count >= 2
//   count           : registered occupancy 0..DEPTH
//   full, empty     : decoded from count
// DEPTH must be a power of two (pointers wrap naturally) and at least 2.
module batcher_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 32,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic [W-1:0]  next_head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_ptr_nxt;
    logic          push_ok;
    logic          pop_ok;

    assign full       = (count == CW'(DEPTH));
    assign empty      = (count == '0);
    assign push_ok    = push && !full;
    assign pop_ok     = pop && !empty;
    assign rd_ptr_nxt = rd_ptr + AW'(1);
    assign head       = mem[rd_ptr];
    // The framer needs the following record's upper half in the same cycle
    // it pops the current one, so the second entry is exposed as well.
    assign next_head  = mem[rd_ptr_nxt];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr_nxt;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/axis_sample_batcher.sv
// Collects 64-bit sample records into batches of BATCH_LEN and emits each
// batch as a 32-bit AXI-Stream frame:
//   MAGIC, {frame_seq, 8'h00, BATCH_LEN}, then hi/lo words per record.
// Optional macro BATCHER_CHECKSUM_EN appends a trailer word holding the
// mod-2^32 sum of all header and data words; tlast then sits on the trailer.
// Ports:
//   aclk, aresetn            : clock, synchronous active-low reset
//   s_axis_tdata/tvalid/tready : record input; tready = FIFO not full
//   m_axis_tdata/tvalid/tready/tlast : registered frame output
//   drop_count               : saturating count of records lost on full FIFO
//   frame_seq                : sequence number of the next frame to be sent
// Handshake: a word transfers on a rising edge where tvalid && tready; while
// tvalid && !tready the output word and tlast are held unchanged.
module axis_sample_batcher
    import batcher_pkg::*;
#(
    parameter int          BATCH_LEN  = 16,
    parameter int          FIFO_DEPTH = 32,
    parameter logic [31:0] MAGIC      = DEFAULT_MAGIC
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [63:0]       s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [31:0]       m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic [DROP_W-1:0] drop_count,
    output logic [SEQ_W-1:0]  frame_seq
);

    localparam int               CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0]    BATCH_CNT = CW'(BATCH_LEN);
    localparam logic [LEN_W-1:0] LEN_FIELD = LEN_W'(BATCH_LEN);
    localparam logic [LEN_W-1:0] LAST_IDX  = LEN_W'(BATCH_LEN - 1);

    batcher_state_t    state_q, state_d;
    logic [31:0]       data_d;
    logic              valid_d, last_d;
    logic [LEN_W-1:0]  rec_q, rec_d;
    logic [SEQ_W-1:0]  seq_q;
    logic [DROP_W-1:0] drop_q;
    logic              fire, push, pop;
    logic              frame_done, more, seq_inc, start_frame;
    logic [63:0]       head, next_head;
    logic [CW-1:0]     count;
    logic              full, empty;
    logic              unused_fifo;

    assign s_axis_tready = !full;
    assign push          = s_axis_tvalid && !full;
    assign fire          = m_axis_tvalid && m_axis_tready;
    assign drop_count    = drop_q;
    assign frame_seq     = seq_q;
    assign unused_fifo   = &{1'b0, next_head[31:0], empty};

    batcher_fifo #(
        .W     (64),
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk       (aclk),
        .rst_n     (aresetn),
        .push      (push),
        .wdata     (s_axis_tdata),
        .pop       (pop),
        .head      (head),
        .next_head (next_head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

`ifdef BATCHER_CHECKSUM_EN
    logic [31:0] acc_q;

    // Start-of-frame clear wins over the add of the previous frame's trailer.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            acc_q <= '0;
        end else if (start_frame) begin
            acc_q <= '0;
        end else if (fire) begin
            acc_q <= acc_q + m_axis_tdata;
        end
    end
`endif

    // state_q names the word currently presented on the output registers.
    always_comb begin
        state_d     = state_q;
        data_d      = m_axis_tdata;
        valid_d     = m_axis_tvalid;
        last_d      = m_axis_tlast;
        rec_d       = rec_q;
        pop         = 1'b0;
        frame_done  = 1'b0;
        more        = 1'b0;
        seq_inc     = 1'b0;
        start_frame = 1'b0;
        case (state_q)
            IDLE: begin
                if (count >= BATCH_CNT) begin
                    state_d     = HDR_MAGIC;
                    data_d      = MAGIC;
                    valid_d     = 1'b1;
                    last_d      = 1'b0;
                    start_frame = 1'b1;
                end
            end
            HDR_MAGIC: begin
                if (fire) begin
                    state_d = HDR_INFO;
                    data_d  = {seq_q, 8'h00, LEN_FIELD};
                end
            end
            HDR_INFO: begin
                if (fire) begin
                    state_d = DATA_HI;
                    data_d  = head[63:32];
                    rec_d   = '0;
                end
            end
            DATA_HI: begin
                if (fire) begin
                    state_d = DATA_LO;
                    data_d  = head[31:0];
`ifdef BATCHER_CHECKSUM_EN
                    last_d  = 1'b0;
`else
                    last_d  = (rec_q == LAST_IDX);
`endif
                end
            end
            DATA_LO: begin
                if (fire) begin
                    pop = 1'b1;
                    if (rec_q != LAST_IDX) begin
                        state_d = DATA_HI;
                        data_d  = next_head[63:32];
                        rec_d   = rec_q + LEN_W'(1);
                    end else begin
`ifdef BATCHER_CHECKSUM_EN
                        state_d = CHECKSUM;
                        data_d  = acc_q + m_axis_tdata;
                        last_d  = 1'b1;
`else
                        // count still includes the record popped this cycle.
                        frame_done = 1'b1;
                        more       = (count > BATCH_CNT);
`endif
                    end
                end
            end
`ifdef BATCHER_CHECKSUM_EN
            CHECKSUM: begin
                if (fire) begin
                    frame_done = 1'b1;
                    more       = (count >= BATCH_CNT);
                end
            end
`endif
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end
        endcase

        // Final word accepted: chain straight into the next frame when a
        // full batch is already resident, otherwise fall back to IDLE.
        if (frame_done) begin
            seq_inc = 1'b1;
            last_d  = 1'b0;
            if (more) begin
                state_d     = HDR_MAGIC;
                data_d      = MAGIC;
                valid_d     = 1'b1;
                start_frame = 1'b1;
            end else begin
                state_d = IDLE;
                data_d  = '0;
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q       <= IDLE;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            rec_q         <= '0;
            seq_q         <= '0;
            drop_q        <= '0;
        end else begin
            state_q       <= state_d;
            m_axis_tdata  <= data_d;
            m_axis_tvalid <= valid_d;
            m_axis_tlast  <= last_d;
            rec_q         <= rec_d;
            if (seq_inc) begin
                seq_q <= seq_q + SEQ_W'(1);
            end
            if (s_axis_tvalid && full && (drop_q != '1)) begin
                drop_q <= drop_q + DROP_W'(1);
            end
        end
    end

endmodule
